conv_layer_sequencer: RTL and testbench

Descriptor-driven layer scheduler for the conv2d DSP engine. Reads a table of 8-word layer descriptors from system memory, programs the engine's address and shape ports, pulses its start, waits for completion, and repeats for `layer_count` layers. The block sits between the host/CPU control registers and the conv engine, and has its own read-only memory port for descriptor fetch.

---
 rtl/conv_layer_sequencer_if.sv | 45 ++++
 rtl/conv_layer_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Descriptor memory read port and conv engine control/parameter port of conv_layer_sequencer.
// master = sequencer side, slave = memory/engine side.
interface conv_layer_sequencer_if;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_ready;
    logic [31:0] mem_data_in;
    logic        mem_rvalid;

    logic        eng_start;
    logic        eng_ready;
    logic        eng_done;
    logic [31:0] eng_input_addr;
    logic [31:0] eng_weights_addr;
    logic [31:0] eng_bias_addr;
    logic [31:0] eng_output_addr;
    logic [15:0] eng_input_height;
    logic [15:0] eng_input_width;
    logic [15:0] eng_output_height;
    logic [15:0] eng_output_width;
    logic [15:0] eng_stride_h;
    logic [15:0] eng_stride_w;
    logic [15:0] eng_pad_h;
    logic [15:0] eng_pad_w;

    modport master (
        output mem_addr, mem_re,
        input  mem_ready, mem_data_in, mem_rvalid,
        output eng_start,
        input  eng_ready, eng_done,
        output eng_input_addr, eng_weights_addr, eng_bias_addr, eng_output_addr,
        output eng_input_height, eng_input_width, eng_output_height, eng_output_width,
        output eng_stride_h, eng_stride_w, eng_pad_h, eng_pad_w
    );

    modport slave (
        input  mem_addr, mem_re,
        output mem_ready, mem_data_in, mem_rvalid,
        input  eng_start,
        output eng_ready, eng_done,
        input  eng_input_addr, eng_weights_addr, eng_bias_addr, eng_output_addr,
        input  eng_input_height, eng_input_width, eng_output_height, eng_output_width,
        input  eng_stride_h, eng_stride_w, eng_pad_h, eng_pad_w
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Descriptor-driven layer scheduler for the conv2d engine: fetches 8-word descriptors and runs them in order.
// Optional per-layer watchdog abort is built when LAYER_WATCHDOG_EN is defined.
//
// state      | meaning
// IDLE       | waiting for start
// FETCH_REQ  | read request for descriptor word word_idx held until accepted
// FETCH_WAIT | waiting for read data of word word_idx
// LAUNCH     | waiting for eng_ready, then copy shadow regs and pulse eng_start
// RUN        | waiting for eng_done (watchdog may abort)
// NEXT       | advance to the next descriptor or finish
// FINISH     | sequence end, done pulse
module conv_layer_sequencer #(
    parameter int LAYER_W   = 8,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          desc_base,
    input  logic [LAYER_W-1:0]   layer_count,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LAYER_W-1:0]   cur_layer,
    conv_layer_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t             state;
    logic [31:0]        desc_ptr;
    logic [2:0]         word_idx;
    logic [LAYER_W-1:0] layer_total;
    logic [31:0]        shadow [8];
    logic               wd_expire;

    always_ff @(posedge clk) begin
        if (state == S_FETCH_WAIT && bus.mem_rvalid) begin
            shadow[word_idx] <= bus.mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= S_IDLE;
            desc_ptr              <= '0;
            word_idx              <= '0;
            layer_total           <= '0;
            cur_layer             <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            bus.mem_addr          <= '0;
            bus.mem_re            <= 1'b0;
            bus.eng_start         <= 1'b0;
            bus.eng_input_addr    <= '0;
            bus.eng_weights_addr  <= '0;
            bus.eng_bias_addr     <= '0;
            bus.eng_output_addr   <= '0;
            bus.eng_input_height  <= '0;
            bus.eng_input_width   <= '0;
            bus.eng_output_height <= '0;
            bus.eng_output_width  <= '0;
            bus.eng_stride_h      <= '0;
            bus.eng_stride_w      <= '0;
            bus.eng_pad_h         <= '0;
            bus.eng_pad_w         <= '0;
        end else begin
            done          <= 1'b0;
            bus.eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (layer_count != '0) begin
                            desc_ptr     <= desc_base;
                            word_idx     <= '0;
                            cur_layer    <= '0;
                            layer_total  <= layer_count;
                            bus.mem_addr <= desc_base;
                            bus.mem_re   <= 1'b1;
                            state        <= S_FETCH_REQ;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FETCH_REQ: begin
                    if (bus.mem_ready) begin
                        bus.mem_re <= 1'b0;
                        state      <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (word_idx == 3'd7) begin
                            state <= S_LAUNCH;
                        end else begin
                            word_idx     <= word_idx + 3'd1;
                            bus.mem_addr <= desc_ptr + {27'd0, word_idx + 3'd1, 2'b00};
                            bus.mem_re   <= 1'b1;
                            state        <= S_FETCH_REQ;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (bus.eng_ready) begin
                        bus.eng_input_addr    <= shadow[0];
                        bus.eng_weights_addr  <= shadow[1];
                        bus.eng_bias_addr     <= shadow[2];
                        bus.eng_output_addr   <= shadow[3];
                        bus.eng_input_height  <= shadow[4][31:16];
                        bus.eng_input_width   <= shadow[4][15:0];
                        bus.eng_output_height <= shadow[5][31:16];
                        bus.eng_output_width  <= shadow[5][15:0];
                        bus.eng_stride_h      <= shadow[6][31:16];
                        bus.eng_stride_w      <= shadow[6][15:0];
                        bus.eng_pad_h         <= shadow[7][31:16];
                        bus.eng_pad_w         <= shadow[7][15:0];
                        bus.eng_start         <= 1'b1;
                        state                 <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.eng_done) begin
                        state <= S_NEXT;
                    end else if (wd_expire) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end
                end
                S_NEXT: begin
                    if (cur_layer + LAYER_W'(1) == layer_total) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        cur_layer    <= cur_layer + LAYER_W'(1);
                        desc_ptr     <= desc_ptr + 32'd32;
                        word_idx     <= '0;
                        bus.mem_addr <= desc_ptr + 32'd32;
                        bus.mem_re   <= 1'b1;
                        state        <= S_FETCH_REQ;
                    end
                end
                S_FINISH: begin
                    // Arriving from RUN/NEXT the pulse is already out; the empty-sequence
                    // path enters with done low and emits it on the way back to IDLE.
                    done  <= ~done;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LAYER_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_cnt;

    assign wd_expire = (timeout_cycles != '0) && (wd_cnt + TIMEOUT_W'(1) == timeout_cycles);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            if (state == S_LAUNCH && bus.eng_ready) begin
                wd_cnt <= '0;
            end else if (state == S_RUN && !bus.eng_done) begin
                wd_cnt <= wd_cnt + TIMEOUT_W'(1);
            end
            if (state == S_IDLE && start) begin
                error <= 1'b0;
            end else if (state == S_RUN && !bus.eng_done && wd_expire) begin
                error <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_cycles;
    assign wd_expire      = 1'b0;
    assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed self-checking bench for conv_layer_sequencer with a zero/multi-wait memory model.
module tb_conv_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] desc_base;
    logic [7:0]  layer_count;
    logic [23:0] timeout_cycles;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  cur_layer;

    conv_layer_sequencer_if bus ();

    conv_layer_sequencer #(.LAYER_W(8), .TIMEOUT_W(24)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .desc_base      (desc_base),
        .layer_count    (layer_count),
        .timeout_cycles (timeout_cycles),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .cur_layer      (cur_layer),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_eng_start = 0;
    int          n_done = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] acc_q [$];
    bit          stall_en = 1'b0;
    int          rv_delay = 1;
    int          ready_until = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.eng_start === 1'b1) n_eng_start <= n_eng_start + 1;
        if (done === 1'b1) n_done <= n_done + 1;
        if (prev_stall && (bus.mem_addr !== prev_addr || bus.mem_re !== 1'b1))
            stall_viol <= stall_viol + 1;
        prev_stall <= (bus.mem_re === 1'b1) && (bus.mem_ready === 1'b0);
        prev_addr  <= bus.mem_addr;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1010) return 32'h0020_0020;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // memory responder: accept when mem_re && mem_ready, return data rv_delay cycles later
    initial begin : mem_model
        bit          acc;
        bit          pend;
        int          pend_cnt;
        logic [31:0] acc_addr;
        logic [31:0] pend_addr;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = '0;
        bus.mem_ready   = 1'b1;
        bus.mem_rvalid  = 1'b0;
        bus.mem_data_in = '0;
        forever begin
            @(negedge clk);
            acc      = (bus.mem_re === 1'b1) && (bus.mem_ready === 1'b1) && (rst_n === 1'b1);
            acc_addr = bus.mem_addr;
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (acc) begin
                pend      = 1'b1;
                pend_cnt  = rv_delay - 1;
                pend_addr = acc_addr;
                acc_q.push_back(acc_addr);
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    bus.mem_rvalid  = 1'b1;
                    bus.mem_data_in = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            bus.mem_ready = stall_en ? ~bus.mem_ready : 1'b1;
        end
    end

    initial begin : eng_ready_drv
        bus.eng_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.eng_ready = (cyc >= ready_until);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_eng_start(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            if (bus.eng_start === 1'b1) begin
                at = cyc;
                break;
            end
            tick(1);
        end
        check("eng_start_seen", bus.eng_start, 1);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
            tick(1);
        end
        check("done_seen", done, 1);
    endtask

    task automatic check_fields(input logic [31:0] base, input int layer);
        logic [31:0] w [8];
        for (int k = 0; k < 8; k++) w[k] = mem_word(base + 32'(32 * layer) + 32'(4 * k));
        check("in_addr",  bus.eng_input_addr,    w[0]);
        check("wt_addr",  bus.eng_weights_addr,  w[1]);
        check("b_addr",   bus.eng_bias_addr,     w[2]);
        check("out_addr", bus.eng_output_addr,   w[3]);
        check("in_h",     bus.eng_input_height,  w[4][31:16]);
        check("in_w",     bus.eng_input_width,   w[4][15:0]);
        check("out_h",    bus.eng_output_height, w[5][31:16]);
        check("out_w",    bus.eng_output_width,  w[5][15:0]);
        check("str_h",    bus.eng_stride_h,      w[6][31:16]);
        check("str_w",    bus.eng_stride_w,      w[6][15:0]);
        check("pad_h",    bus.eng_pad_h,         w[7][31:16]);
        check("pad_w",    bus.eng_pad_w,         w[7][15:0]);
    endtask

    // lat < 0: engine never completes. poke: a second start issued while busy.
    task automatic run_layers(input logic [31:0] base, input int n, input int lat,
                              input int ready_hold, input bit poke,
                              output int launch0, output int rs, output int td, output int dc);
        int t0;
        int at;
        int a0;
        int bad;
        a0 = acc_q.size();
        launch0 = -1;
        rs = -1;
        td = -1;
        dc = -1;
        desc_base   = base;
        layer_count = n[7:0];
        start       = 1'b1;
        t0          = cyc;
        if (ready_hold > 0) ready_until = t0 + 17 + ready_hold;
        tick(1);
        start = 1'b0;
        if (poke) begin
            tick(3);
            desc_base   = 32'h0000_5000;
            layer_count = 8'd5;
            start       = 1'b1;
            tick(1);
            start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            wait_eng_start(at);
            if (at < 0) return;
            if (i == 0) launch0 = at - t0;
            rs = at;
            check("cur_layer", cur_layer, i);
            check_fields(base, i);
            if (lat < 0) break;
            tick(lat);
            bus.eng_done = 1'b1;
            td = cyc;
            tick(1);
            bus.eng_done = 1'b0;
        end
        wait_done(dc);
        tick(1);
        check("done_pulse_len", done, 0);
        check("busy_after", busy, 0);
        check("read_count", acc_q.size() - a0, 8 * n);
        bad = 0;
        for (int j = 0; j < 8 * n && a0 + j < acc_q.size(); j++)
            if (acc_q[a0 + j] !== base + 32'(4 * j)) bad++;
        check("read_addr_errs", bad, 0);
    endtask

    initial begin : driver
        int l0, rs, td, dc, s_es, s_dn, s_sv, a0, at;
        rst_n          = 1'b0;
        start          = 1'b0;
        desc_base      = '0;
        layer_count    = '0;
        timeout_cycles = '0;
        bus.eng_done   = 1'b0;
        tick(3);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_error",   error, 0);
        check("rst_mem_re",  bus.mem_re, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_eng_start", bus.eng_start, 0);
        check("rst_cur_layer", cur_layer, 0);
        check("rst_in_addr", bus.eng_input_addr, 0);
        check("rst_pad_w",   bus.eng_pad_w, 0);
        rst_n = 1'b1;
        tick(2);

        // single layer, reference timing
        s_es = n_eng_start;
        s_dn = n_done;
        run_layers(32'h0000_1000, 1, 5, 0, 1'b0, l0, rs, td, dc);
        check("single_launch_cycle", l0, 18);
        check("single_done_lat", dc - td, 2);
        check("single_in_h32", bus.eng_input_height, 32);
        check("single_in_w32", bus.eng_input_width, 32);
        check("single_eng_starts", n_eng_start - s_es, 1);
        check("single_dones", n_done - s_dn, 1);

        // three layers
        s_es = n_eng_start;
        s_dn = n_done;
        a0   = acc_q.size();
        run_layers(32'h0000_1000, 3, 3, 0, 1'b0, l0, rs, td, dc);
        check("three_fetch2", acc_q[a0 + 8], 32'h0000_1020);
        check("three_fetch3", acc_q[a0 + 16], 32'h0000_1040);
        check("three_eng_starts", n_eng_start - s_es, 3);
        check("three_dones", n_done - s_dn, 1);
        check("three_done_lat", dc - td, 2);

        // memory stalls and slow read data
        stall_en = 1'b1;
        rv_delay = 3;
        s_sv = stall_viol;
        run_layers(32'h0000_2000, 2, 4, 0, 1'b0, l0, rs, td, dc);
        check("stall_addr_stable", stall_viol - s_sv, 0);
        check("stall_done_lat", dc - td, 2);
        stall_en = 1'b0;
        rv_delay = 1;
        tick(2);

        // eng_ready held low for 10 LAUNCH cycles
        run_layers(32'h0000_1000, 1, 2, 10, 1'b0, l0, rs, td, dc);
        check("ready_hold_launch", l0, 28);

        // start while busy is ignored
        s_es = n_eng_start;
        s_dn = n_done;
        run_layers(32'h0000_3000, 1, 4, 0, 1'b1, l0, rs, td, dc);
        check("poke_launch", l0, 18);
        check("poke_eng_starts", n_eng_start - s_es, 1);
        check("poke_dones", n_done - s_dn, 1);

        // descriptor pointer wraps past 2^32
        a0 = acc_q.size();
        run_layers(32'hFFFF_FFF0, 2, 3, 0, 1'b0, l0, rs, td, dc);
        check("wrap_fetch2", acc_q[a0 + 8], 32'h0000_0010);

        // watchdog
        timeout_cycles = 24'd100;
`ifdef LAYER_WATCHDOG_EN
        run_layers(32'h0000_1000, 1, -1, 0, 1'b0, l0, rs, td, dc);
        check("wd_done_after_run", dc - rs, 100);
        check("wd_error", error, 1);
        tick(5);
        check("wd_error_sticky", error, 1);
`else
        run_layers(32'h0000_1000, 1, 150, 0, 1'b0, l0, rs, td, dc);
        check("nowd_done_lat", dc - td, 2);
        check("nowd_error", error, 0);
`endif
        // completion in the expiry cycle wins over timeout
        timeout_cycles = 24'd10;
        run_layers(32'h0000_1000, 1, 9, 0, 1'b0, l0, rs, td, dc);
        check("wd_tie_done_lat", dc - td, 2);
        check("wd_tie_error", error, 0);
        timeout_cycles = 24'd0;

        // layer_count == 0
        a0   = acc_q.size();
        s_dn = n_done;
        layer_count = 8'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("zero_busy_c1", busy, 1);
        check("zero_done_c1", done, 0);
        check("zero_error_clr", error, 0);
        tick(1);
        check("zero_done_c2", done, 1);
        check("zero_busy_c2", busy, 0);
        tick(1);
        check("zero_done_c3", done, 0);
        check("zero_reads", acc_q.size() - a0, 0);
        check("zero_dones", n_done - s_dn, 1);

        // reset during RUN of layer 1
        s_dn = n_done;
        desc_base   = 32'h0000_1000;
        layer_count = 8'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_eng_start(at);
        tick(2);
        bus.eng_done = 1'b1;
        tick(1);
        bus.eng_done = 1'b0;
        wait_eng_start(at);
        check("mid_cur_layer", cur_layer, 1);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_mem_re", bus.mem_re, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        check("mid_rst_eng_start", bus.eng_start, 0);
        check("mid_rst_cur_layer", cur_layer, 0);
        check("mid_rst_in_addr", bus.eng_input_addr, 0);
        check("mid_rst_in_h", bus.eng_input_height, 0);
        rst_n = 1'b1;
        tick(1);
        bus.eng_done = 1'b1;
        tick(1);
        bus.eng_done = 1'b0;
        tick(5);
        check("mid_rst_no_done", n_done - s_dn, 0);
        check("mid_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
